// File: rtl/cpu4_mem_pkg.sv
// Shared types and constants for the 4-bit CPU bus memory responder.
package cpu4_mem_pkg;

  localparam int DEF_ADDR_W = 6;
  localparam int DEF_DATA_W = 4;

  localparam logic [7:0] WR_COUNT_MAX = 8'd255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/cpu4_nibble_ram.sv
// Flop-array nibble store: one synchronous write port, one combinational
// read port, cleared synchronously while rst_n is low.
module cpu4_nibble_ram
  import cpu4_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Clear the whole image on reset, otherwise take the single write port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/cpu4_bus_memory.sv
// Memory-side responder for the 4-bit accumulator CPU: serves bus reads from
// a registered address, captures stores on write cycles, and accepts a full
// 64-nibble image through a valid/ready loader.
module cpu4_bus_memory
  import cpu4_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] bus_in,
  input  logic              bus_wr,
  output logic [DATA_W-1:0] bus_rdata,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              ld_done,
  output logic [7:0]        wr_count
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] r_addr_q;
  logic [7:0]        r_wr_count;
  logic              r_ld_done;

  logic              w_in_load;
  logic              w_bus_en;
  logic              w_load_fire;
  logic              w_load_last;
  logic              w_bus_store;
  logic              w_ram_we;
  logic [ADDR_W-1:0] w_ram_waddr;
  logic [DATA_W-1:0] w_ram_wdata;
  logic [DATA_W-1:0] w_ram_rdata;

  // Next-state and state-decoded controls; ld_ready depends on state only.
  always_comb begin
    w_state_nxt = r_state;
    w_in_load   = 1'b0;
    w_bus_en    = 1'b0;
    case (r_state)
      IDLE, RUN: begin
        w_bus_en = 1'b1;
        if (ld_start) begin
          w_state_nxt = LOAD;
        end
      end
      LOAD: begin
        w_in_load = 1'b1;
        if (w_load_last) begin
          w_state_nxt = RUN;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // A restart in LOAD wins over a simultaneous nibble, which is dropped.
  assign w_load_fire = w_in_load && ld_valid && !ld_start;
  assign w_load_last = w_load_fire && (r_ptr == '1);
  assign w_bus_store = w_bus_en && bus_wr;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Loader pointer: zeroed on any ld_start, wraps to 0 after entry 63.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (ld_start) begin
      r_ptr <= '0;
    end else if (w_load_fire) begin
      r_ptr <= r_ptr + ADDR_W'(1);
    end
  end

  // Load-complete flag: cleared when a load begins, set on the final transfer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ld_done <= 1'b0;
    end else if (ld_start) begin
      r_ld_done <= 1'b0;
    end else if (w_load_last) begin
      r_ld_done <= 1'b1;
    end
  end

  // Bus address register: captured on non-write cycles, held across writes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_addr_q <= '0;
    end else if (w_bus_en && !bus_wr) begin
      r_addr_q <= bus_in;
    end
  end

  // Saturating count of serviced CPU write cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_count <= '0;
    end else if (w_bus_store && (r_wr_count != WR_COUNT_MAX)) begin
      r_wr_count <= r_wr_count + 8'd1;
    end
  end

  // Write port belongs to the loader in LOAD and to the bus otherwise.
  assign w_ram_we    = w_load_fire || w_bus_store;
  assign w_ram_waddr = w_in_load ? r_ptr   : r_addr_q;
  assign w_ram_wdata = w_in_load ? ld_data : bus_in[DATA_W-1:0];

  cpu4_nibble_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_ram_we),
    .i_waddr (w_ram_waddr),
    .i_wdata (w_ram_wdata),
    .i_raddr (r_addr_q),
    .o_rdata (w_ram_rdata)
  );

  assign bus_rdata = w_in_load ? '0 : w_ram_rdata;
  assign ld_ready  = w_in_load;
  assign ld_done   = r_ld_done;
  assign wr_count  = r_wr_count;

endmodule

// File: tb/tb_cpu4_bus_memory.sv
// Self-checking bench for cpu4_bus_memory: a directed vector table, hand-built
// loader/bus sequences, and a randomized run against a behavioural model.
module tb_cpu4_bus_memory;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] bus_in;
  logic       bus_wr;
  logic [3:0] bus_rdata;
  logic       ld_start;
  logic       ld_valid;
  logic [3:0] ld_data;
  logic       ld_ready;
  logic       ld_done;
  logic [7:0] wr_count;

  int checks = 0;
  int errors = 0;

  cpu4_bus_memory #(.ADDR_W(6), .DATA_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus_in    (bus_in),
    .bus_wr    (bus_wr),
    .bus_rdata (bus_rdata),
    .ld_start  (ld_start),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_ready  (ld_ready),
    .ld_done   (ld_done),
    .wr_count  (wr_count)
  );

  always #5 clk = ~clk;

  // Behavioural model: the store as a plain array, a mode flag for
  // "loading or not", the loader position, and the bus's last read address.
  int m_mem [64];
  int m_addr;
  bit m_loading;
  int m_ptr;
  int m_done;
  int m_cnt;

  function automatic void model_edge(input bit r, input int bi, input bit bw,
                                     input bit st, input bit vv, input int d);
    if (!r) begin
      foreach (m_mem[i]) m_mem[i] = 0;
      m_addr = 0; m_loading = 0; m_ptr = 0; m_done = 0; m_cnt = 0;
      return;
    end
    if (m_loading) begin
      if (st) begin
        m_ptr = 0;
        m_done = 0;
      end else if (vv) begin
        m_mem[m_ptr] = d % 16;
        m_ptr = m_ptr + 1;
        if (m_ptr == 64) begin
          m_ptr = 0;
          m_loading = 0;
          m_done = 1;
        end
      end
    end else begin
      if (bw) begin
        m_mem[m_addr] = bi % 16;
        if (m_cnt < 255) m_cnt = m_cnt + 1;
      end else begin
        m_addr = bi % 64;
      end
      if (st) begin
        m_loading = 1;
        m_ptr = 0;
        m_done = 0;
      end
    end
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: drive, advance the model on the edge, then compare off-edge.
  task automatic step(input bit r, input int bi, input bit bw,
                      input bit st, input bit vv, input int d);
    rst_n    = r;
    bus_in   = 6'(bi);
    bus_wr   = bw;
    ld_start = st;
    ld_valid = vv;
    ld_data  = 4'(d);
    @(posedge clk);
    model_edge(r, bi, bw, st, vv, d);
    #1;
    chk("model_rdata", int'(bus_rdata), m_loading ? 0 : m_mem[m_addr]);
    chk("model_ready", int'(ld_ready), int'(m_loading));
    chk("model_done", int'(ld_done), m_done);
    chk("model_wrcnt", int'(wr_count), m_cnt);
  endtask

  task automatic rd(input int a);
    step(1'b1, a, 1'b0, 1'b0, 1'b0, 0);
  endtask

  typedef struct {
    bit rst_n;
    int bus_in;
    bit bus_wr;
    bit st;
    bit vv;
    int d;
    int e_rdata;
    int e_ready;
    int e_done;
    int e_cnt;
  } vec_t;

  vec_t tbl [10];

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // rst, bus_in, wr, start, valid, data | rdata, ready, done, wr_count
    tbl[0] = '{0, 6'h00, 0, 0, 0, 0,   0, 0, 0, 0};
    tbl[1] = '{1, 6'h15, 0, 0, 0, 0,   0, 0, 0, 0};
    tbl[2] = '{1, 6'h09, 1, 0, 0, 0,   9, 0, 0, 1};
    tbl[3] = '{1, 6'h16, 0, 0, 0, 0,   0, 0, 0, 1};
    tbl[4] = '{1, 6'h15, 0, 0, 0, 0,   9, 0, 0, 1};
    tbl[5] = '{1, 6'h23, 1, 0, 0, 0,   3, 0, 0, 2};
    tbl[6] = '{1, 6'h00, 0, 1, 0, 0,   0, 1, 0, 2};
    tbl[7] = '{1, 6'h15, 0, 0, 1, 10,  0, 1, 0, 2};
    tbl[8] = '{0, 6'h00, 0, 0, 0, 0,   0, 0, 0, 0};
    tbl[9] = '{1, 6'h00, 0, 0, 0, 0,   0, 0, 0, 0};

    rst_n = 1'b0; bus_in = '0; bus_wr = 1'b0;
    ld_start = 1'b0; ld_valid = 1'b0; ld_data = '0;
    m_loading = 0;
    model_edge(1'b0, 0, 1'b0, 1'b0, 1'b0, 0);

    foreach (tbl[i]) begin
      step(tbl[i].rst_n, tbl[i].bus_in, tbl[i].bus_wr, tbl[i].st, tbl[i].vv, tbl[i].d);
      chk($sformatf("tbl%0d_rdata", i), int'(bus_rdata), tbl[i].e_rdata);
      chk($sformatf("tbl%0d_ready", i), int'(ld_ready), tbl[i].e_ready);
      chk($sformatf("tbl%0d_done", i), int'(ld_done), tbl[i].e_done);
      chk($sformatf("tbl%0d_wrcnt", i), int'(wr_count), tbl[i].e_cnt);
    end

    // Full image load with idle gaps; done only on the 64th accepted nibble.
    step(1'b1, 0, 1'b0, 1'b1, 1'b0, 0);
    for (int i = 0; i < 64; i++) begin
      while ($urandom_range(0, 3) == 0) step(1'b1, 0, 1'b0, 1'b0, 1'b0, 0);
      step(1'b1, $urandom_range(0, 63), 1'b0, 1'b0, 1'b1, i % 16);
      if (i == 62) chk("load_done_early", int'(ld_done), 0);
      if (i == 63) chk("load_done_last", int'(ld_done), 1);
    end
    chk("load_ready_after", int'(ld_ready), 0);
    rd(6'h05); chk("load_rd05", int'(bus_rdata), 5);
    rd(6'h1F); chk("load_rd1F", int'(bus_rdata), 15);
    rd(6'h3F); chk("load_rd3F", int'(bus_rdata), 15);

    // Store in RUN: write targets the last read address, neighbour untouched.
    rd(6'h0A); chk("run_rd0A", int'(bus_rdata), 10);
    step(1'b1, 6'h03, 1'b1, 1'b0, 1'b0, 0);
    chk("run_wr_rdata", int'(bus_rdata), 3);
    chk("run_wr_count", int'(wr_count), 1);
    rd(6'h0B); chk("run_rd0B", int'(bus_rdata), 11);
    rd(6'h0A); chk("run_rd0A_new", int'(bus_rdata), 3);

    // Restart mid-load at ptr=20 with a simultaneous nibble that must drop.
    step(1'b1, 0, 1'b0, 1'b1, 1'b0, 0);
    for (int i = 0; i < 20; i++) step(1'b1, 0, 1'b0, 1'b0, 1'b1, 5);
    step(1'b1, 0, 1'b0, 1'b1, 1'b1, 7);
    for (int i = 0; i < 64; i++) begin
      step(1'b1, 0, 1'b0, 1'b0, 1'b1, (~i) & 15);
      if (i == 43) chk("restart_not_done_44", int'(ld_done), 0);
      if (i == 62) chk("restart_not_done_63", int'(ld_done), 0);
      if (i == 63) chk("restart_done_64", int'(ld_done), 1);
    end
    rd(20); chk("restart_rd20", int'(bus_rdata), 11);
    rd(0);  chk("restart_rd00", int'(bus_rdata), 15);

    // 300 back-to-back writes: counter pins at 255.
    rd(6'h10);
    for (int k = 0; k < 300; k++) begin
      step(1'b1, k % 64, 1'b1, 1'b0, 1'b0, 0);
      if (k == 252) chk("sat_at_254", int'(wr_count), 254);
      if (k == 253) chk("sat_at_255", int'(wr_count), 255);
    end
    chk("sat_final", int'(wr_count), 255);
    chk("sat_rdata", int'(bus_rdata), 299 % 16);

    // Reset in the middle of a load discards everything.
    step(1'b1, 0, 1'b0, 1'b1, 1'b0, 0);
    for (int i = 0; i < 40; i++) step(1'b1, 0, 1'b0, 1'b0, 1'b1, i % 16);
    step(1'b0, 0, 1'b0, 1'b0, 1'b1, 9);
    chk("rst_ready", int'(ld_ready), 0);
    chk("rst_done", int'(ld_done), 0);
    chk("rst_wrcnt", int'(wr_count), 0);
    rd(6'h03); chk("rst_rd03", int'(bus_rdata), 0);
    rd(6'h0A); chk("rst_rd0A", int'(bus_rdata), 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 399) != 0),
           $urandom_range(0, 63),
           ($urandom_range(0, 9) < 3),
           ($urandom_range(0, 299) == 0),
           $urandom_range(0, 1),
           $urandom_range(0, 15));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
